// File: rtl/rename_dispatch_ss_pkg.sv
// Shared types for the rename/dispatch stage.
// Inter-stage bundles between the instruction queue and ROB/RS.
package rename_dispatch_ss_pkg;

  localparam int PR_W     = 6;
  localparam int ROB_ID_W = 3;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [4:0]  rd_s;
    logic        rs1_needed;
    logic        rs2_needed;
  } instruction_info_reg_t;

  typedef struct packed {
    logic [PR_W-1:0] rs1;
    logic [PR_W-1:0] rs2;
    logic [PR_W-1:0] rd;
  } rat_info_t;

  typedef struct packed {
    logic [63:0] order;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [4:0]  rd_s;
  } rvfi_info_t;

  typedef struct packed {
    logic [ROB_ID_W-1:0] rob_id;
    logic                commit;
    logic                input1_met;
    logic                input2_met;
    rat_info_t           rat;
    rvfi_info_t          rvfi;
  } dispatch_reservation_t;

endpackage

// File: rtl/rename_bypass_ss.sv
// Intra-group RAW bypass for source renaming.
// Younger lanes see the pd of the youngest older writer.
module rename_bypass_ss #(
  parameter int SS  = 2,
  parameter int PRW = 6
) (
  input  logic [SS-1:0]  lane_alloc,
  input  logic [4:0]     rd_s  [SS],
  input  logic [4:0]     rs1_s [SS],
  input  logic [4:0]     rs2_s [SS],
  input  logic [PRW-1:0] rat1  [SS],
  input  logic [PRW-1:0] rat2  [SS],
  input  logic [PRW-1:0] pd    [SS],
  output logic [PRW-1:0] src1  [SS],
  output logic [PRW-1:0] src2  [SS],
  output logic [SS-1:0]  byp1,
  output logic [SS-1:0]  byp2
);

  // Walk older lanes in order so the highest match wins.
  always_comb begin
    byp1 = '0;
    byp2 = '0;
    for (int j = 0; j < SS; j++) begin
      src1[j] = rat1[j];
      src2[j] = rat2[j];
      for (int i = 0; i < j; i++) begin
        if (lane_alloc[i] && rd_s[i] == rs1_s[j]) begin
          src1[j] = pd[i];
          byp1[j] = 1'b1;
        end
        if (lane_alloc[i] && rd_s[i] == rs2_s[j]) begin
          src2[j] = pd[i];
          byp2[j] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rename_dispatch_ss.sv
// Superscalar rename/dispatch with partial-group acceptance.
// Registers the renamed group toward ROB/RS.
module rename_dispatch_ss
  import rename_dispatch_ss_pkg::*;
#(
  parameter int SS         = 2,
  parameter int PR_ENTRIES = 64,
  parameter int ROB_DEPTH  = 8,
  parameter int CDB_PORTS  = 1,
  localparam int PRW = $clog2(PR_ENTRIES),
  localparam int RIW = $clog2(ROB_DEPTH),
  localparam int CW  = $clog2(SS+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid    [SS],
  input  instruction_info_reg_t in_inst     [SS],
  output logic [CW-1:0]         in_accept_cnt,
  output logic [4:0]            rat_rs1_isa [SS],
  output logic [4:0]            rat_rs2_isa [SS],
  input  logic [PRW-1:0]        rat_rs1_pr  [SS],
  input  logic [PRW-1:0]        rat_rs2_pr  [SS],
  output logic                  rat_we      [SS],
  output logic [4:0]            rat_wr_isa  [SS],
  output logic [PRW-1:0]        rat_wr_pr   [SS],
  input  logic [PRW-1:0]        fl_regs     [SS],
  input  logic [PRW:0]          fl_count,
  output logic [CW-1:0]         fl_pop_cnt,
  input  logic [PR_ENTRIES-1:0] pr_ready,
  input  logic                  cdb_valid   [CDB_PORTS],
  input  logic [PRW-1:0]        cdb_pr      [CDB_PORTS],
  input  logic [RIW:0]          rob_free,
  input  logic [RIW-1:0]        rob_id_next [SS],
  input  logic [CW-1:0]         rs_free,
  output logic                  out_valid   [SS],
  output dispatch_reservation_t out_entry   [SS],
  input  logic                  out_ready
);

  logic                  adv, acc;
  logic [CW-1:0]         k;
  logic [CW-1:0]         need [SS];
  logic [SS-1:0]         alloc, lane_acc;
  logic [SS-1:0]         byp1, byp2, rdy1, rdy2;
  logic [PRW-1:0]        pd   [SS];
  logic [PRW-1:0]        src1 [SS];
  logic [PRW-1:0]        src2 [SS];
  logic [4:0]            rd_v [SS];
  logic [SS-1:0]         out_valid_q, out_valid_d;
  dispatch_reservation_t out_entry_q [SS];
  dispatch_reservation_t out_entry_d [SS];

  // Capacity checks, prefix length and destination allocation.
  always_comb begin
    int cnt;
    logic ok;
    adv = ~(|out_valid_q) | out_ready;
    acc = rst & adv & ~flush;
    cnt = 0;
    ok  = 1'b1;
    k   = '0;
    for (int i = 0; i < SS; i++) begin
      rd_v[i]  = in_inst[i].rd_s;
      alloc[i] = in_valid[i] & (in_inst[i].rd_s != 5'd0);
      cnt      = cnt + (alloc[i] ? 1 : 0);
      need[i]  = CW'(cnt);
      ok = ok & in_valid[i]
        & ((i + 1) <= int'(rob_free))
        & ((i + 1) <= int'(rs_free))
        & (cnt <= int'(fl_count));
      if (ok) k = CW'(i + 1);
    end
    in_accept_cnt = acc ? k : '0;
    fl_pop_cnt    = '0;
    for (int i = 0; i < SS; i++) begin
      lane_acc[i] = acc & (i < int'(k));
      if (lane_acc[i]) fl_pop_cnt = need[i];
      pd[i] = '0;
      for (int m = 0; m < SS; m++) begin
        if (alloc[i] && (m + 1) == int'(need[i])) pd[i] = fl_regs[m];
      end
    end
  end

  rename_bypass_ss #(.SS(SS), .PRW(PRW)) u_byp (
    .lane_alloc (alloc),
    .rd_s       (rd_v),
    .rs1_s      (rat_rs1_isa),
    .rs2_s      (rat_rs2_isa),
    .rat1       (rat_rs1_pr),
    .rat2       (rat_rs2_pr),
    .pd         (pd),
    .src1       (src1),
    .src2       (src2),
    .byp1       (byp1),
    .byp2       (byp2)
  );

  // RAT ports; only the youngest writer of an rd updates the RAT.
  always_comb begin
    for (int i = 0; i < SS; i++) begin
      rat_rs1_isa[i] = in_inst[i].rs1_s;
      rat_rs2_isa[i] = in_inst[i].rs2_s;
      rat_wr_isa[i]  = in_inst[i].rd_s;
      rat_wr_pr[i]   = pd[i];
      rat_we[i]      = lane_acc[i] & alloc[i];
      for (int m = i + 1; m < SS; m++) begin
        if (lane_acc[m] && alloc[m] && rd_v[m] == rd_v[i])
          rat_we[i] = 1'b0;
      end
    end
  end

  // Source readiness from scoreboard, CDB and x0.
  always_comb begin
    for (int i = 0; i < SS; i++) begin
      rdy1[i] = pr_ready[src1[i]] | (src1[i] == '0);
      rdy2[i] = pr_ready[src2[i]] | (src2[i] == '0);
      for (int c = 0; c < CDB_PORTS; c++) begin
        if (cdb_valid[c] && cdb_pr[c] == src1[i]) rdy1[i] = 1'b1;
        if (cdb_valid[c] && cdb_pr[c] == src2[i]) rdy2[i] = 1'b1;
      end
      if (byp1[i]) rdy1[i] = 1'b0;
      if (byp2[i]) rdy2[i] = 1'b0;
      if (!in_inst[i].rs1_needed) rdy1[i] = 1'b1;
      if (!in_inst[i].rs2_needed) rdy2[i] = 1'b1;
    end
  end

  // Next output group: load, hold with wakeup, or squash.
  always_comb begin
    out_valid_d = out_valid_q;
    out_entry_d = out_entry_q;
    if (flush) begin
      out_valid_d = '0;
    end else if (adv) begin
      for (int i = 0; i < SS; i++) begin
        out_valid_d[i]               = lane_acc[i];
        out_entry_d[i]               = '0;
        out_entry_d[i].rob_id        = rob_id_next[i];
        out_entry_d[i].commit        = 1'b0;
        out_entry_d[i].input1_met    = rdy1[i];
        out_entry_d[i].input2_met    = rdy2[i];
        out_entry_d[i].rat.rs1       = src1[i];
        out_entry_d[i].rat.rs2       = src2[i];
        out_entry_d[i].rat.rd        = pd[i];
        out_entry_d[i].rvfi.inst     = in_inst[i].inst;
        out_entry_d[i].rvfi.pc       = in_inst[i].pc;
        out_entry_d[i].rvfi.rs1_s    = in_inst[i].rs1_s;
        out_entry_d[i].rvfi.rs2_s    = in_inst[i].rs2_s;
        out_entry_d[i].rvfi.rd_s     = in_inst[i].rd_s;
      end
    end else begin
      for (int i = 0; i < SS; i++) begin
        for (int c = 0; c < CDB_PORTS; c++) begin
          if (out_valid_q[i] && cdb_valid[c]) begin
            if (cdb_pr[c] == out_entry_q[i].rat.rs1)
              out_entry_d[i].input1_met = 1'b1;
            if (cdb_pr[c] == out_entry_q[i].rat.rs2)
              out_entry_d[i].input2_met = 1'b1;
          end
        end
      end
    end
  end

  // Output group register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= '0;
      for (int i = 0; i < SS; i++) out_entry_q[i] <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      for (int i = 0; i < SS; i++) out_entry_q[i] <= out_entry_d[i];
    end
  end

  // Drive the registered group onto the ports.
  always_comb begin
    for (int i = 0; i < SS; i++) begin
      out_valid[i] = out_valid_q[i];
      out_entry[i] = out_entry_q[i];
    end
  end

endmodule

// File: tb/tb_rename_dispatch_ss.sv
// Directed bench for rename_dispatch_ss (SS=2).
// Hand-computed expectations, immediate assertions.
module tb_rename_dispatch_ss;
  import rename_dispatch_ss_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  flush;
  logic                  in_valid    [2];
  instruction_info_reg_t in_inst     [2];
  logic [1:0]            in_accept_cnt;
  logic [4:0]            rat_rs1_isa [2];
  logic [4:0]            rat_rs2_isa [2];
  logic [5:0]            rat_rs1_pr  [2];
  logic [5:0]            rat_rs2_pr  [2];
  logic                  rat_we      [2];
  logic [4:0]            rat_wr_isa  [2];
  logic [5:0]            rat_wr_pr   [2];
  logic [5:0]            fl_regs     [2];
  logic [6:0]            fl_count;
  logic [1:0]            fl_pop_cnt;
  logic [63:0]           pr_ready;
  logic                  cdb_valid   [1];
  logic [5:0]            cdb_pr      [1];
  logic [3:0]            rob_free;
  logic [2:0]            rob_id_next [2];
  logic [1:0]            rs_free;
  logic                  out_valid   [2];
  dispatch_reservation_t out_entry   [2];
  logic                  out_ready;

  logic [5:0] rat_tb [32];
  int vectors = 0;
  int miscompares = 0;

  rename_dispatch_ss dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_inst(in_inst),
    .in_accept_cnt(in_accept_cnt),
    .rat_rs1_isa(rat_rs1_isa), .rat_rs2_isa(rat_rs2_isa),
    .rat_rs1_pr(rat_rs1_pr), .rat_rs2_pr(rat_rs2_pr),
    .rat_we(rat_we), .rat_wr_isa(rat_wr_isa), .rat_wr_pr(rat_wr_pr),
    .fl_regs(fl_regs), .fl_count(fl_count), .fl_pop_cnt(fl_pop_cnt),
    .pr_ready(pr_ready), .cdb_valid(cdb_valid), .cdb_pr(cdb_pr),
    .rob_free(rob_free), .rob_id_next(rob_id_next), .rs_free(rs_free),
    .out_valid(out_valid), .out_entry(out_entry), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rat_rs1_pr[i] = rat_tb[rat_rs1_isa[i]];
      rat_rs2_pr[i] = rat_tb[rat_rs2_isa[i]];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    flush      = 1'b0;
    out_ready  = 1'b1;
    rob_free   = 4'd8;
    rs_free    = 2'd2;
    fl_count   = 7'd10;
    cdb_valid[0] = 1'b0;
    cdb_pr[0]  = '0;
    for (int i = 0; i < 2; i++) begin
      in_valid[i]    = 1'b0;
      in_inst[i]     = '0;
      fl_regs[i]     = 6'(40 + i);
      rob_id_next[i] = 3'(i);
    end
  endtask

  task automatic lane(input int i, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic n1, input logic n2);
    in_inst[i]            = '0;
    in_inst[i].pc         = 32'h100 + 32'(i * 4);
    in_inst[i].inst       = 32'h33 + 32'(rd);
    in_inst[i].rd_s       = rd;
    in_inst[i].rs1_s      = rs1;
    in_inst[i].rs2_s      = rs2;
    in_inst[i].rs1_needed = n1;
    in_inst[i].rs2_needed = n2;
    in_valid[i]           = 1'b1;
  endtask

  initial begin
    for (int r = 0; r < 32; r++) rat_tb[r] = 6'(r);
    pr_ready = '1;
    rst = 1'b0;
    idle();
    lane(0, 5'd3, 5'd1, 5'd2, 1, 1);
    #1;
    chk("rst_valid0", 64'(out_valid[0]), 0);
    chk("rst_valid1", 64'(out_valid[1]), 0);
    chk("rst_accept", 64'(in_accept_cnt), 0);
    chk("rst_pop", 64'(fl_pop_cnt), 0);
    chk("rst_we0", 64'(rat_we[0]), 0);
    @(negedge clk);
    rst = 1'b1;

    // 1: RAW bypass inside the group
    @(negedge clk);
    idle();
    lane(0, 5'd3, 5'd1, 5'd2, 1, 1);
    lane(1, 5'd4, 5'd3, 5'd1, 1, 1);
    #1;
    chk("t1_accept", 64'(in_accept_cnt), 2);
    chk("t1_pop", 64'(fl_pop_cnt), 2);
    chk("t1_we0", 64'(rat_we[0]), 1);
    chk("t1_we1", 64'(rat_we[1]), 1);
    chk("t1_wpr0", 64'(rat_wr_pr[0]), 40);
    chk("t1_wpr1", 64'(rat_wr_pr[1]), 41);
    @(posedge clk); #1;
    chk("t1_ov0", 64'(out_valid[0]), 1);
    chk("t1_ov1", 64'(out_valid[1]), 1);
    chk("t1_l0_rd", 64'(out_entry[0].rat.rd), 40);
    chk("t1_l0_rs2", 64'(out_entry[0].rat.rs2), 2);
    chk("t1_l1_rs1", 64'(out_entry[1].rat.rs1), 40);
    chk("t1_l1_met1", 64'(out_entry[1].input1_met), 0);
    chk("t1_l1_rs2", 64'(out_entry[1].rat.rs2), 1);
    chk("t1_l1_met2", 64'(out_entry[1].input2_met), 1);
    chk("t1_l1_rob", 64'(out_entry[1].rob_id), 1);
    chk("t1_l1_commit", 64'(out_entry[1].commit), 0);

    // 2: rd=x0 lane needs no free register
    @(negedge clk);
    idle();
    fl_count   = 7'd1;
    fl_regs[0] = 6'd20;
    fl_regs[1] = 6'd21;
    lane(0, 5'd0, 5'd1, 5'd0, 1, 0);
    lane(1, 5'd5, 5'd6, 5'd0, 1, 0);
    #1;
    chk("t2_accept", 64'(in_accept_cnt), 2);
    chk("t2_pop", 64'(fl_pop_cnt), 1);
    chk("t2_we0", 64'(rat_we[0]), 0);
    chk("t2_we1", 64'(rat_we[1]), 1);
    chk("t2_wpr1", 64'(rat_wr_pr[1]), 20);
    @(posedge clk); #1;
    chk("t2_l0_rd", 64'(out_entry[0].rat.rd), 0);
    chk("t2_l1_rd", 64'(out_entry[1].rat.rd), 20);

    // 3: ROB capacity limits the group
    @(negedge clk);
    idle();
    rob_free   = 4'd1;
    fl_regs[0] = 6'd50;
    fl_regs[1] = 6'd51;
    lane(0, 5'd8, 5'd1, 5'd2, 1, 1);
    lane(1, 5'd9, 5'd1, 5'd2, 1, 1);
    #1;
    chk("t3_accept", 64'(in_accept_cnt), 1);
    chk("t3_pop", 64'(fl_pop_cnt), 1);
    chk("t3_we1", 64'(rat_we[1]), 0);
    @(posedge clk); #1;
    chk("t3_ov0", 64'(out_valid[0]), 1);
    chk("t3_ov1", 64'(out_valid[1]), 0);
    chk("t3_l0_rd", 64'(out_entry[0].rat.rd), 50);
    @(negedge clk);
    idle();
    rob_free   = 4'd2;
    fl_regs[0] = 6'd51;
    fl_regs[1] = 6'd52;
    lane(0, 5'd9, 5'd1, 5'd2, 1, 1);
    #1;
    chk("t3b_accept", 64'(in_accept_cnt), 1);
    chk("t3b_wpr0", 64'(rat_wr_pr[0]), 51);
    @(posedge clk); #1;
    chk("t3b_l0_rd", 64'(out_entry[0].rat.rd), 51);
    chk("t3b_l0_isa", 64'(out_entry[0].rvfi.rd_s), 9);

    // 4: both lanes write x7
    @(negedge clk);
    idle();
    fl_regs[0] = 6'd30;
    fl_regs[1] = 6'd31;
    lane(0, 5'd7, 5'd1, 5'd2, 1, 1);
    lane(1, 5'd7, 5'd7, 5'd2, 1, 1);
    #1;
    chk("t4_we0", 64'(rat_we[0]), 0);
    chk("t4_we1", 64'(rat_we[1]), 1);
    chk("t4_wisa1", 64'(rat_wr_isa[1]), 7);
    chk("t4_wpr1", 64'(rat_wr_pr[1]), 31);
    @(posedge clk); #1;
    chk("t4_l1_rs1", 64'(out_entry[1].rat.rs1), 30);
    chk("t4_l1_met1", 64'(out_entry[1].input1_met), 0);
    chk("t4_l1_rd", 64'(out_entry[1].rat.rd), 31);

    // boundaries
    @(negedge clk);
    idle();
    fl_count = 7'd0;
    lane(0, 5'd0, 5'd1, 5'd2, 1, 1);
    lane(1, 5'd0, 5'd2, 5'd1, 1, 1);
    #1;
    chk("b_fl0_accept", 64'(in_accept_cnt), 2);
    chk("b_fl0_pop", 64'(fl_pop_cnt), 0);
    @(negedge clk);
    idle();
    fl_count = 7'd1;
    lane(0, 5'd10, 5'd1, 5'd2, 1, 1);
    lane(1, 5'd11, 5'd1, 5'd2, 1, 1);
    #1;
    chk("b_fl1_accept", 64'(in_accept_cnt), 1);
    @(negedge clk);
    idle();
    rs_free = 2'd0;
    lane(0, 5'd10, 5'd1, 5'd2, 1, 1);
    lane(1, 5'd11, 5'd1, 5'd2, 1, 1);
    #1;
    chk("b_rs0_accept", 64'(in_accept_cnt), 0);
    chk("b_rs0_we0", 64'(rat_we[0]), 0);
    @(negedge clk);
    idle();
    rob_free = 4'd0;
    lane(0, 5'd10, 5'd1, 5'd2, 1, 1);
    #1;
    chk("b_rob0_accept", 64'(in_accept_cnt), 0);
    @(negedge clk);
    idle();
    rs_free = 2'd1;
    lane(0, 5'd10, 5'd1, 5'd2, 1, 1);
    lane(1, 5'd11, 5'd1, 5'd2, 1, 1);
    #1;
    chk("b_rs1_accept", 64'(in_accept_cnt), 1);

    // 5: held entry woken by CDB
    @(negedge clk);
    idle();
    pr_ready[12] = 1'b0;
    rat_tb[10]   = 6'd12;
    lane(0, 5'd11, 5'd10, 5'd0, 1, 0);
    #1;
    chk("t5_accept", 64'(in_accept_cnt), 1);
    @(posedge clk); #1;
    chk("t5_ov0", 64'(out_valid[0]), 1);
    chk("t5_rs1", 64'(out_entry[0].rat.rs1), 12);
    chk("t5_met1", 64'(out_entry[0].input1_met), 0);
    chk("t5_met2", 64'(out_entry[0].input2_met), 1);
    @(negedge clk);
    idle();
    out_ready = 1'b0;
    lane(0, 5'd13, 5'd1, 5'd2, 1, 1);
    #1;
    chk("t5_hold_accept", 64'(in_accept_cnt), 0);
    chk("t5_hold_pop", 64'(fl_pop_cnt), 0);
    @(posedge clk); #1;
    chk("t5_h1_ov0", 64'(out_valid[0]), 1);
    chk("t5_h1_isa", 64'(out_entry[0].rvfi.rd_s), 11);
    chk("t5_h1_met1", 64'(out_entry[0].input1_met), 0);
    @(negedge clk);
    cdb_valid[0] = 1'b1;
    cdb_pr[0]    = 6'd12;
    @(posedge clk); #1;
    chk("t5_h2_met1", 64'(out_entry[0].input1_met), 1);
    @(negedge clk);
    cdb_valid[0] = 1'b0;
    #1;
    chk("t5_h3_accept", 64'(in_accept_cnt), 0);
    @(posedge clk); #1;
    chk("t5_h3_ov0", 64'(out_valid[0]), 1);
    chk("t5_h3_isa", 64'(out_entry[0].rvfi.rd_s), 11);
    chk("t5_h3_met1", 64'(out_entry[0].input1_met), 1);
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("t5_rel_accept", 64'(in_accept_cnt), 1);
    @(posedge clk); #1;
    chk("t5_rel_isa", 64'(out_entry[0].rvfi.rd_s), 13);
    pr_ready[12] = 1'b1;

    // 6: flush, then asynchronous reset
    @(negedge clk);
    idle();
    flush = 1'b1;
    lane(0, 5'd14, 5'd1, 5'd2, 1, 1);
    lane(1, 5'd15, 5'd1, 5'd2, 1, 1);
    #1;
    chk("t6_fl_accept", 64'(in_accept_cnt), 0);
    chk("t6_fl_pop", 64'(fl_pop_cnt), 0);
    chk("t6_fl_we0", 64'(rat_we[0]), 0);
    @(posedge clk); #1;
    chk("t6_fl_ov0", 64'(out_valid[0]), 0);
    chk("t6_fl_ov1", 64'(out_valid[1]), 0);
    @(negedge clk);
    flush = 1'b0;
    @(posedge clk); #1;
    chk("t6_ld_ov1", 64'(out_valid[1]), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_ov0", 64'(out_valid[0]), 0);
    chk("t6_rst_ov1", 64'(out_valid[1]), 0);
    chk("t6_rst_accept", 64'(in_accept_cnt), 0);
    chk("t6_rst_we1", 64'(rat_we[1]), 0);
    @(negedge clk);
    rst = 1'b1;
    idle();
    @(posedge clk); #1;
    chk("t6_post_ov0", 64'(out_valid[0]), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rename_dispatch_ss.md
Name: rename_dispatch_ss

Overview:
Superscalar rename/dispatch stage, generalised to SS lanes with partial-group dispatch. It renames sources through the RAT and bypasses RAW dependencies inside a group. It allocates free-list registers only for lanes that write rd, bounds dispatch by ROB, RS and free-list capacity, and registers the renamed group toward ROB/RS with a valid/ready handshake. It sits between the instruction queue and the ROB/reservation stations.

Parameters:
SS, 2, lanes per group (1..8)
PR_ENTRIES, 64, physical registers; PRW = $clog2(PR_ENTRIES)
ROB_DEPTH, 8, ROB entries; RIW = $clog2(ROB_DEPTH)
CDB_PORTS, 1, wakeup broadcasts per cycle

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-low reset
flush  input  1  squash the output register and ignore the input group this cycle
in_valid[SS]  input  1  lane valid; the valid lanes are contiguous from lane 0
in_inst[SS]  input  instruction_info_reg_t  decoded instruction (rs1_s, rs2_s, rd_s, rs1_needed, rs2_needed, …)
in_accept_cnt  output  $clog2(SS+1)  lanes consumed this cycle; the instruction queue pops this many
rat_rs1_isa[SS], rat_rs2_isa[SS]  output  5  RAT read addresses
rat_rs1_pr[SS], rat_rs2_pr[SS]  input  PRW  RAT read data (combinational)
rat_we[SS]  output  1  RAT write enable
rat_wr_isa[SS]  output  5  RAT write address
rat_wr_pr[SS]  output  PRW  RAT write data
fl_regs[SS]  input  PRW  the next SS free-list entries, head first
fl_count  input  PRW+1  free-list occupancy
fl_pop_cnt  output  $clog2(SS+1)  free registers consumed
pr_ready  input  PR_ENTRIES  scoreboard; bit p=1 means p's value is produced
cdb_valid[CDB_PORTS]  input  1  wakeup valid
cdb_pr[CDB_PORTS]  input  PRW  wakeup tag
rob_free  input  RIW+1  free ROB slots
rob_id_next[SS]  input  RIW  ROB ids for lanes 0..SS-1
rs_free  input  $clog2(SS+1)  RS slots available (saturated at SS)
out_valid[SS]  output  1  registered lane valid
out_entry[SS]  output  dispatch_reservation_t  registered renamed entry
out_ready  input  1  ROB/RS accept the whole registered group

Behaviour:
- Output register:
  - adv = ~(|out_valid) | out_ready.
  - Latency 1 cycle from acceptance to out_valid.
- Allocation:
  - alloc_i = in_valid[i] & (rd_s != 0).
  - need_i = number of allocating lanes among 0..i.
- Lane i is dispatchable when all of these hold:
  - lanes 0..i are all valid
  - i+1 <= rob_free
  - i+1 <= rs_free
  - need_i <= fl_count
- k = largest dispatchable prefix length.
- Accept:
  - in_accept_cnt = (adv & ~flush) ? k : 0.
  - fl_pop_cnt = need_(k-1) over the accepted lanes.
  - Lanes at index >= k are not touched and stay in the queue.
- Destination:
  - Lane i's pd = fl_regs[need_i - 1] when alloc_i.
  - When rd_s = 0: pd = 0 and rat_we = 0.
- Source rename for lane j (rs1 and rs2 alike):
  - Start from the RAT value.
  - Override it with the pd of the highest accepted lane i<j where alloc_i and rd_s_i == rs_s_j.
- RAT write:
  - rat_we[i] = accepted & alloc_i.
  - When several lanes write the same rd, only the highest lane writes the RAT.
- Readiness (input1_met, input2_met):
  - Source not needed → 1.
  - Source bypassed intra-group → 0.
  - Otherwise pr_ready[p] | any(cdb_valid & cdb_pr == p) | p == 0.
- Registered entry fields:
  - rob_id = rob_id_next[i]; commit = 0.
  - rat.rs1, rat.rs2, rat.rd are the renamed registers.
  - rvfi fields come from in_inst.
  - rvfi.order is left to the ROB.
- Wakeup on held entries: while out_valid and ~out_ready, CDB matches on a held entry's sources set its met bits.
- Flush:
  - out_valid clears next cycle.
  - Nothing is accepted that cycle.
  - No RAT, free-list or queue side effects that cycle.
- Reset (rst=0, asynchronous):
  - All out_valid = 0.
  - Combinational outputs fall to their idle values: counts 0, rat_we 0.
  - Reset mid-group discards the held group.
- Boundaries:
  - fl_count=0 still dispatches lanes with rd=0.
  - rob_free=0 or rs_free=0 → k=0.
  - adv=0 → k=0 and the output is held stable.

Decomposition:
- rv32i_types gains:
  - PR_W
  - ROB_ID_W
  - the dispatch_reservation_t met bits, if missing
- Sub-module rename_bypass_ss (purely combinational):
  - inputs: lane valid/rd/rs, RAT pr, pd
  - outputs: renamed sources and bypass flags
  - instantiated once.

Test Plan:
1. SS=2; lanes add x3←x1,x2 and add x4←x3,x1; fl_regs={40,41}; rob_free=8 → in_accept_cnt=2, fl_pop_cnt=2, lane1.rat.rs1=40, lane1 input1_met=0, rat_we={1,1}.
2. Lane0 rd=x0, lane1 rd=x5; fl_count=1, fl_regs={20,21} → both accepted, lane0.rd=0, lane1.rd=20, fl_pop_cnt=1.
3. rob_free=1, two valid lanes → in_accept_cnt=1; the next cycle with rob_free=2 dispatches the remaining lane.
4. Both lanes write x7 (pd 30, 31) → one RAT write, x7→31; lane1 rs1=x7 renames to 30.
5. out_ready=0 for 3 cycles, and cdb_pr=12 pulses on a held source → entry held, in_accept_cnt=0, input1_met becomes 1.
6. flush with out_valid=1 and a valid input group → out_valid=0 next cycle, in_accept_cnt=0; rst=0 asynchronously mid-cycle → out_valid=0 immediately.
